// File: rtl/stab_pkg.sv
// Shared definitions for the stabilizer row decomposition block.
//   LIT_*            : 2-bit Pauli literal encoding (bit1 = x, bit0 = z)
//   phase_t          : phase as a power of i (0:+1, 1:+i, 2:-1, 3:-i)
//   state_e          : decomposer FSM states
//   lit_imag_factor  : power of i produced by multiplying two single-qubit literals
package stab_pkg;

    localparam logic [1:0] LIT_I = 2'b00;
    localparam logic [1:0] LIT_Z = 2'b01;
    localparam logic [1:0] LIT_X = 2'b10;
    localparam logic [1:0] LIT_Y = 2'b11;

    typedef logic [1:0] phase_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Cyclic order X->Y->Z gives +i, anti-cyclic gives -i (= i^3).
    function automatic phase_t lit_imag_factor(input logic [1:0] a, input logic [1:0] b);
        phase_t f;
        f = 2'd0;
        case ({a, b})
            {LIT_X, LIT_Y}, {LIT_Y, LIT_Z}, {LIT_Z, LIT_X}: f = 2'd1;
            {LIT_Y, LIT_X}, {LIT_Z, LIT_Y}, {LIT_X, LIT_Z}: f = 2'd3;
            default:                                       f = 2'd0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pauli_row_prod.sv
// Combinational product of two Pauli rows, A*B, with exact mod-4 phase.
//   a_phase_i, a_lit_i : left operand (phase as power of i, literals)
//   b_phase_i, b_lit_i : right operand
//   p_phase_o, p_lit_o : product row
module pauli_row_prod
    import stab_pkg::*;
#(
    parameter int num_qubit = 4
) (
    input  logic [1:0]             a_phase_i,
    input  logic [2*num_qubit-1:0] a_lit_i,
    input  logic [1:0]             b_phase_i,
    input  logic [2*num_qubit-1:0] b_lit_i,
    output logic [1:0]             p_phase_o,
    output logic [2*num_qubit-1:0] p_lit_o
);

    phase_t acc;

    always_comb begin
        acc = a_phase_i + b_phase_i;
        for (int unsigned q = 0; q < num_qubit; q++) begin
            acc = acc + lit_imag_factor(a_lit_i[2*q +: 2], b_lit_i[2*q +: 2]);
        end
        p_phase_o = acc;
        p_lit_o   = a_lit_i ^ b_lit_i;
    end

endmodule

// File: rtl/stab_row_decompose.sv
// Decomposes a query Pauli row over a fully reduced generator set, one
// generator row per clock.
//   clk, rst_n                      : clock, async active-low reset
//   gen_literals/phase/pivot_*/row_valid : generator set (unregistered, held
//                                     stable from query acceptance to result)
//   query_valid/ready, query_*      : query handshake and payload
//   result_valid/ready, result_*    : membership, selection mask, residual phase
module stab_row_decompose
    import stab_pkg::*;
#(
    parameter int num_qubit = 4,
    parameter int IDXW      = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2*num_qubit*num_qubit-1:0] gen_literals,
    input  logic [num_qubit-1:0]             gen_phase,
    input  logic [IDXW*num_qubit-1:0]        gen_pivot_col,
    input  logic [num_qubit-1:0]             gen_pivot_bit,
    input  logic [num_qubit-1:0]             gen_row_valid,
    input  logic                             query_valid,
    output logic                             query_ready,
    input  logic [2*num_qubit-1:0]           query_literals,
    input  logic [1:0]                       query_phase,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic                             result_member,
    output logic [num_qubit-1:0]             result_select,
    output logic [1:0]                       result_phase
);

    localparam int LW = 2 * num_qubit;

    state_e               state_q, state_d;
    logic [IDXW-1:0]      row_q, row_d;
    logic [LW-1:0]        q_lit_q, q_lit_d;
    phase_t               q_ph_q, q_ph_d;
    logic [LW-1:0]        p_lit_q, p_lit_d;
    phase_t               p_ph_q, p_ph_d;
    logic [num_qubit-1:0] sel_q, sel_d;

    logic [LW-1:0]        row_lit;
    logic [IDXW-1:0]      piv_col;
    logic                 piv_bit;
    logic                 take;
    logic [LW-1:0]        prod_lit;
    phase_t               prod_ph;

    assign row_lit = gen_literals[int'(row_q)*LW +: LW];
    assign piv_col = gen_pivot_col[int'(row_q)*IDXW +: IDXW];
    assign piv_bit = gen_pivot_bit[row_q];

    // In reduced form only row r has its pivot column set, so the query bit
    // there alone decides whether row r is in the product.
    always_comb begin
        take = 1'b0;
        if (gen_row_valid[row_q] && (int'(piv_col) < num_qubit)) begin
            take = q_lit_q[int'(piv_col)*2 + int'(piv_bit)];
        end
    end

    pauli_row_prod #(.num_qubit(num_qubit)) u_prod (
        .a_phase_i (p_ph_q),
        .a_lit_i   (p_lit_q),
        .b_phase_i ({gen_phase[row_q], 1'b0}),
        .b_lit_i   (row_lit),
        .p_phase_o (prod_ph),
        .p_lit_o   (prod_lit)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        q_lit_d      = q_lit_q;
        q_ph_d       = q_ph_q;
        p_lit_d      = p_lit_q;
        p_ph_d       = p_ph_q;
        sel_d        = sel_q;
        query_ready  = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                query_ready = 1'b1;
                if (query_valid) begin
                    q_lit_d = query_literals;
                    q_ph_d  = query_phase;
                    p_lit_d = '0;
                    p_ph_d  = '0;
                    sel_d   = '0;
                    row_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (take) begin
                    p_lit_d       = prod_lit;
                    p_ph_d        = prod_ph;
                    sel_d[row_q]  = 1'b1;
                end
                if (row_q == IDXW'(num_qubit - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign result_member = result_valid && (p_lit_q == q_lit_q);
    assign result_select = result_valid ? sel_q : '0;
    assign result_phase  = result_valid ? phase_t'(q_ph_q - p_ph_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            q_lit_q <= '0;
            q_ph_q  <= '0;
            p_lit_q <= '0;
            p_ph_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            q_lit_q <= q_lit_d;
            q_ph_q  <= q_ph_d;
            p_lit_q <= p_lit_d;
            p_ph_q  <= p_ph_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_stab_row_decompose.sv
module tb_stab_row_decompose;

    localparam int NQ   = 4;
    localparam int LW   = 2 * NQ;
    localparam int IDXW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [LW*NQ-1:0]     gen_literals = '0;
    logic [NQ-1:0]        gen_phase = '0;
    logic [IDXW*NQ-1:0]   gen_pivot_col = '0;
    logic [NQ-1:0]        gen_pivot_bit = '0;
    logic [NQ-1:0]        gen_row_valid = '0;
    logic                 query_valid = 1'b0;
    logic                 query_ready;
    logic [LW-1:0]        query_literals = '0;
    logic [1:0]           query_phase = '0;
    logic                 result_valid;
    logic                 result_ready = 1'b0;
    logic                 result_member;
    logic [NQ-1:0]        result_select;
    logic [1:0]           result_phase;

    int vectors = 0;
    int errors  = 0;

    // generator set as seen by the bench
    logic [LW-1:0]   g_lit [NQ];
    logic            g_ph  [NQ];
    logic [IDXW-1:0] g_col [NQ];
    logic            g_bit [NQ];
    logic [NQ-1:0]   g_val;
    logic [LW-1:0]   pivot_used;

    stab_row_decompose #(.num_qubit(NQ)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .gen_literals   (gen_literals),
        .gen_phase      (gen_phase),
        .gen_pivot_col  (gen_pivot_col),
        .gen_pivot_bit  (gen_pivot_bit),
        .gen_row_valid  (gen_row_valid),
        .query_valid    (query_valid),
        .query_ready    (query_ready),
        .query_literals (query_literals),
        .query_phase    (query_phase),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_member  (result_member),
        .result_select  (result_select),
        .result_phase   (result_phase)
    );

    always #5 clk = ~clk;

    // Reference product via the symplectic form P = i^(x.z) X^x Z^z:
    // (X^x1 Z^z1)(X^x2 Z^z2) = (-1)^(z1 x2) X^(x1^x2) Z^(z1^z2).
    // Returns {phase, literals}.
    function automatic logic [LW+1:0] model_mul(input logic [LW-1:0] al, input logic [1:0] ap,
                                                input logic [LW-1:0] bl, input logic [1:0] bp);
        int e;
        logic x1, z1, x2, z2, x3, z3;
        e = int'(ap) + int'(bp);
        for (int q = 0; q < NQ; q++) begin
            x1 = al[2*q+1]; z1 = al[2*q];
            x2 = bl[2*q+1]; z2 = bl[2*q];
            x3 = x1 ^ x2;   z3 = z1 ^ z2;
            e = e + int'(x1 & z1) + int'(x2 & z2) + 2*int'(z1 & x2) + 4 - int'(x3 & z3);
        end
        return {2'(e % 4), al ^ bl};
    endfunction

    task automatic drive_gens();
        for (int r = 0; r < NQ; r++) begin
            gen_literals[r*LW +: LW]      = g_lit[r];
            gen_phase[r]                  = g_ph[r];
            gen_pivot_col[r*IDXW +: IDXW] = g_col[r];
            gen_pivot_bit[r]              = g_bit[r];
        end
        gen_row_valid = g_val;
    endtask

    // Two-qubit set from the worked examples: G0=+XX (pivot q0.x), G1=+ZZ (pivot q0.z).
    task automatic load_xx_zz(input logic [NQ-1:0] val);
        for (int r = 0; r < NQ; r++) begin
            g_lit[r] = '0; g_ph[r] = 1'b0; g_col[r] = IDXW'(r); g_bit[r] = 1'b0;
        end
        g_lit[0] = 8'h0A; g_col[0] = 2'd0; g_bit[0] = 1'b1;
        g_lit[1] = 8'h05; g_col[1] = 2'd0; g_bit[1] = 1'b0;
        g_val = val;
        drive_gens();
    endtask

    // Random reduced set: distinct pivot bit positions, each pivot bit set only in its own row.
    task automatic make_random_gens();
        int pos [NQ];
        int p;
        logic [LW-1:0] tmp;
        pivot_used = '0;
        for (int r = 0; r < NQ; r++) begin
            do p = int'($urandom_range(0, LW-1)); while (pivot_used[p]);
            pivot_used[p] = 1'b1;
            pos[r]   = p;
            g_col[r] = IDXW'(p / 2);
            g_bit[r] = 1'(p % 2);
            g_ph[r]  = 1'($urandom);
            g_lit[r] = LW'($urandom);
        end
        for (int r = 0; r < NQ; r++) begin
            tmp = g_lit[r];
            for (int r2 = 0; r2 < NQ; r2++) tmp[pos[r2]] = (r == r2);
            g_lit[r] = tmp;
        end
        g_val = NQ'($urandom);
        drive_gens();
    endtask

    task automatic run_query(input logic [LW-1:0] l, input logic [1:0] p,
                             output logic [NQ-1:0] s, output logic m, output logic [1:0] ph,
                             output int lat);
        int n;
        n = 0;
        while (!query_ready && n < 50) begin @(posedge clk); #1; n++; end
        query_literals = l; query_phase = p; query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        lat = 0;
        while (!result_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        s = result_select; m = result_member; ph = result_phase;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if (query_ready !== 1'b1 || result_valid !== 1'b0 || result_member !== 1'b0 ||
            result_select !== '0 || result_phase !== 2'd0) begin
            errors++;
            $display("FAIL reset: got rdy=%b vld=%b mem=%b sel=%b ph=%0d, want 1 0 0 0000 0",
                     query_ready, result_valid, result_member, result_select, result_phase);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        logic [LW-1:0] ql [4]  = '{8'h0F, 8'h0A, 8'h02, 8'h00};
        logic [1:0]    qp [4]  = '{2'd2, 2'd0, 2'd0, 2'd1};
        logic [NQ-1:0] es [4]  = '{4'b0011, 4'b0001, 4'b0001, 4'b0000};
        logic          em [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]    ep [4]  = '{2'd0, 2'd0, 2'd0, 2'd1};
        logic [NQ-1:0] s; logic m; logic [1:0] ph; int lat;
        load_xx_zz(4'b0011);
        for (int i = 0; i < 4; i++) begin
            run_query(ql[i], qp[i], s, m, ph, lat);
            vectors++;
            if (s !== es[i] || m !== em[i] || ph !== ep[i] || lat !== NQ) begin
                errors++;
                $display("FAIL known[%0d]: got sel=%b mem=%b ph=%0d lat=%0d, want sel=%b mem=%b ph=%0d lat=%0d",
                         i, s, m, ph, lat, es[i], em[i], ep[i], NQ);
            end
            vectors++;
            if (result_valid !== 1'b0 || query_ready !== 1'b1) begin
                errors++;
                $display("FAIL known_release[%0d]: got vld=%b rdy=%b, want 0 1", i, result_valid, query_ready);
            end
        end
    endtask

    task automatic test_hold();
        logic [NQ-1:0] s0; logic m0; logic [1:0] p0;
        int n;
        load_xx_zz(4'b0011);
        query_literals = 8'h0F; query_phase = 2'd2; query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 50) begin @(posedge clk); #1; n++; end
        s0 = result_select; m0 = result_member; p0 = result_phase;
        for (int c = 0; c < 3; c++) begin
            query_valid = 1'b1; query_literals = 8'h05; query_phase = 2'd3;
            @(posedge clk); #1;
            query_valid = 1'b0;
            vectors++;
            if (result_valid !== 1'b1 || query_ready !== 1'b0 || result_select !== s0 ||
                result_member !== m0 || result_phase !== p0 || s0 !== 4'b0011) begin
                errors++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b sel=%b mem=%b ph=%0d, want 1 0 0011 %b %0d",
                         c, result_valid, query_ready, result_select, result_member, result_phase, m0, p0);
            end
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (result_valid !== 1'b0 || query_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_stray_accept: got vld=%b rdy=%b, want 0 1", result_valid, query_ready);
        end
    endtask

    task automatic test_invalid_rows();
        logic [NQ-1:0] s; logic m; logic [1:0] ph; int lat;
        load_xx_zz(4'b0001);
        run_query(8'h05, 2'd3, s, m, ph, lat);
        vectors++;
        if (s !== 4'b0000 || m !== 1'b0 || ph !== 2'd3 || lat !== NQ) begin
            errors++;
            $display("FAIL invalid_zz: got sel=%b mem=%b ph=%0d lat=%0d, want 0000 0 3 %0d", s, m, ph, lat, NQ);
        end
        load_xx_zz(4'b0000);
        run_query(8'h00, 2'd2, s, m, ph, lat);
        vectors++;
        if (s !== 4'b0000 || m !== 1'b1 || ph !== 2'd2 || lat !== NQ) begin
            errors++;
            $display("FAIL none_valid_ii: got sel=%b mem=%b ph=%0d lat=%0d, want 0000 1 2 %0d", s, m, ph, lat, NQ);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [NQ-1:0] s; logic m; logic [1:0] ph; int lat;
        load_xx_zz(4'b0011);
        query_literals = 8'h0F; query_phase = 2'd2; query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (query_ready !== 1'b1 || result_valid !== 1'b0 || result_member !== 1'b0 ||
            result_select !== '0 || result_phase !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_scan: got rdy=%b vld=%b mem=%b sel=%b ph=%0d, want 1 0 0 0000 0",
                     query_ready, result_valid, result_member, result_select, result_phase);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_query(8'h0A, 2'd3, s, m, ph, lat);
        vectors++;
        if (s !== 4'b0001 || m !== 1'b1 || ph !== 2'd3 || lat !== NQ) begin
            errors++;
            $display("FAIL after_reset: got sel=%b mem=%b ph=%0d lat=%0d, want 0001 1 3 %0d", s, m, ph, lat, NQ);
        end
    endtask

    task automatic test_random();
        logic [NQ-1:0] s, sub; logic m; logic [1:0] ph, qp, eph; int lat;
        logic [LW+1:0] acc;
        logic [LW-1:0] ql;
        logic noise;
        int p;
        for (int it = 0; it < 40; it++) begin
            make_random_gens();
            sub = NQ'($urandom) & g_val;
            acc = '0;
            for (int r = 0; r < NQ; r++)
                if (sub[r]) acc = model_mul(acc[LW-1:0], acc[LW+1:LW], g_lit[r], {g_ph[r], 1'b0});
            ql = acc[LW-1:0];
            noise = 1'($urandom);
            if (noise) begin
                do p = int'($urandom_range(0, LW-1)); while (pivot_used[p]);
                ql[p] = ~ql[p];
            end
            qp  = 2'($urandom);
            eph = qp - acc[LW+1:LW];
            run_query(ql, qp, s, m, ph, lat);
            vectors++;
            if (s !== sub || m !== !noise || ph !== eph || lat !== NQ) begin
                errors++;
                $display("FAIL random[%0d]: q=%h qp=%0d got sel=%b mem=%b ph=%0d lat=%0d, want sel=%b mem=%b ph=%0d lat=%0d",
                         it, ql, qp, s, m, ph, lat, sub, !noise, eph, NQ);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [$];
        logic will_acc;
        load_xx_zz(4'b0011);
        query_literals = 8'h0F; query_phase = 2'd0;
        query_valid = 1'b1; result_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            will_acc = query_ready;
            @(posedge clk); #1;
            if (will_acc) acc_cyc.push_back(c);
        end
        query_valid = 1'b0; result_ready = 1'b0;
        vectors++;
        if (acc_cyc.size() < 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d accepts, want at least 3", acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (acc_cyc[i] - acc_cyc[i-1] !== NQ + 2) begin
                    errors++;
                    $display("FAIL b2b_interval[%0d]: got %0d, want %0d", i, acc_cyc[i] - acc_cyc[i-1], NQ + 2);
                end
            end
        end
        repeat (NQ + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_known();
        test_hold();
        test_invalid_rows();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stab_row_decompose.md
Name: stab_row_decompose

Overview:
- Inverse of the frame's row-multiply path. Takes a query Pauli row and a stabilizer generator set that is already in fully reduced row-echelon form.
- Finds the subset of generators whose ordered product equals the query. Reports membership, the selection mask, and the residual phase as a full power of i.
- Sits beside the row-multiply datapath in the stabilizer-frame emulator. Used for measurement-outcome determination and frame consistency checks.
- Processes one generator row per clock, with valid/ready handshakes on the query and result sides.

Parameters:
- num_qubit, 4, qubits per row; also the maximum number of generator rows.
- IDXW, $clog2(num_qubit) (minimum 1), width of a pivot column index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- gen_literals  in  2*num_qubit*num_qubit  row r, qubit q at bits [2*(r*num_qubit+q)+:2]. Encoding: I=0, Z=1, X=2, Y=3 (bit1 = x, bit0 = z).
- gen_phase  in  num_qubit  sign of row r (1 = negative).
- gen_pivot_col  in  IDXW*num_qubit  pivot qubit of row r.
- gen_pivot_bit  in  num_qubit  pivot bit of row r (1 = x bit, 0 = z bit).
- gen_row_valid  in  num_qubit  row r is populated.
- query_valid  in  1  query offered.
- query_ready  out  1  block idle, can accept.
- query_literals  in  2*num_qubit  query row, same encoding.
- query_phase  in  2  query phase as a power of i (0 = +1, 1 = +i, 2 = -1, 3 = -i).
- result_valid  out  1  result held.
- result_ready  in  1  consumer accepts result.
- result_member  out  1  product of selected rows equals query literals.
- result_select  out  num_qubit  bit r set = generator r selected.
- result_phase  out  2  k such that query = i^k · (G_r0·G_r1·…), with selected rows in ascending index order.

Behaviour:
- Reset (async, rst_n low): state IDLE, query_ready=1, result_valid=0, result_member=0, result_select=0, result_phase=0, accumulator cleared to identity with phase 0.
- Generator inputs must be stable from query acceptance until result_valid. They are not registered.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - query_ready=1.
  - On query_valid and query_ready at an edge: latch query_literals and query_phase, clear accumulator P (all I, phase 0), set row index to 0, go to SCAN.
- SCAN:
  - query_ready=0. One row r per cycle, r = 0 to num_qubit-1.
  - Row r is selected iff gen_row_valid[r]=1 AND the latched query bit (qubit gen_pivot_col[r], bit gen_pivot_bit[r]) is 1.
  - This is valid because in fully reduced form no other row has that binary column set.
  - If selected: P ← P·G_r, and set select[r].
  - Literal product: per-qubit XOR.
  - Phase product (2-bit, mod 4): P.phase + 2·gen_phase[r] + Σ f(P_q, G_q), where:
    - f = 1 for (X,Y), (Y,Z), (Z,X);
    - f = 3 for (Y,X), (Z,Y), (X,Z);
    - f = 0 otherwise.
  - All additions wrap mod 4. Nothing is ignored; ±i residuals are kept.
  - After processing row num_qubit-1, go to DONE.
- DONE:
  - Entered exactly num_qubit edges after the acceptance edge.
  - result_valid=1, result_member=(P.literals == query), result_select=select, result_phase=(query_phase − P.phase) mod 4.
  - Outputs are held stable while result_ready=0.
  - On result_ready=1 at an edge: result_valid←0, go to IDLE, query_ready=1 in the next cycle. No same-cycle re-accept, so minimum initiation interval is num_qubit+2 cycles.
- Boundary conditions:
  - query_valid while busy is ignored; the query is not consumed.
  - All gen_row_valid=0: select=0, member=(query is all I), phase=query_phase.
  - A pivot index ≥ num_qubit on a valid row is a protocol error: treat the row as not selected.
  - rst_n asserted during SCAN or DONE aborts immediately to the reset state. No partial result is emitted.

Decomposition:
- Package stab_pkg holds:
  - literal encoding constants LIT_I/LIT_Z/LIT_X/LIT_Y;
  - the phase-encoding typedef (2-bit power of i);
  - function lit_imag_factor(a, b) returning f.
- One combinational sub-module, pauli_row_prod (parameter num_qubit). Inputs: two rows, each a 2-bit phase plus literals. Outputs: the product row with exact mod-4 phase. Instantiated once inside the SCAN datapath.

Test Plan:
- num_qubit=2, generators G0=+XX (pivot 0, x bit) and G1=+ZZ (pivot 0, z bit), query YY with phase 2 → after 2 cycles: select=2'b11, member=1, phase=0 (XX·ZZ = −YY).
- Same generators, query +XX (phase 0) → select=01, member=1, phase=0.
- Same generators, query XI → select=01, member=0. Also query II with phase 1 → select=00, member=1, phase=1.
- Hold result_ready low 3 cycles → result_valid stays 1, outputs unchanged, query_ready=0, extra query_valid pulses are not accepted.
- gen_row_valid=2'b01, query ZZ → select=00, member=0. gen_row_valid=0, query II → member=1.
- Deassert rst_n mid-SCAN → next cycle all outputs at reset values, query_ready=1. A fresh query then completes correctly.
